// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit adder that processes one CHUNK-bit
// slice per clock and ripples the carry between slices in a register.
// A start/busy/done handshake brackets each operation. The outputs sum, carry
// and overflow change only when an operation completes.
// Optional feature: define ADDSUB_EN to add a 'sub' input that selects A - B
// (computed as A + ~B + 1); without it the block is add-only.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  // Reject slice sizes that do not tile the operand width exactly.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_chunk_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             run_carry;

  logic [WIDTH-1:0] eff_b;
  logic             eff_c;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             msb_cin;
  logic [WIDTH-1:0] acc_next;

  // Subtraction is folded into the captured operands so the datapath only adds.
`ifdef ADDSUB_EN
  assign eff_b = sub ? ~b : b;
  assign eff_c = sub ? 1'b1 : cin;
`else
  assign eff_b = b;
  assign eff_c = cin;
`endif

  // One slice of the adder plus the accumulator with the new slice merged in.
  always_comb begin
    a_slice = opa[idx*CHUNK +: CHUNK];
    b_slice = opb[idx*CHUNK +: CHUNK];
    {slice_cout, slice_sum} = {1'b0, a_slice} + {1'b0, b_slice}
                              + {{CHUNK{1'b0}}, run_carry};
    // Carry into the top bit of this slice, recovered from its sum bit.
    msb_cin = slice_sum[CHUNK-1] ^ a_slice[CHUNK-1] ^ b_slice[CHUNK-1];
    acc_next = acc;
    acc_next[idx*CHUNK +: CHUNK] = slice_sum;
  end

  // Control FSM and datapath registers; results are published only on the last slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      run_carry <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa       <= a;
            opb       <= eff_b;
            run_carry <= eff_c;
            idx       <= '0;
            acc       <= '0;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          acc       <= acc_next;
          run_carry <= slice_cout;
          if (idx == LAST) begin
            sum      <= acc_next;
            carry    <= slice_cout;
            overflow <= msb_cin ^ slice_cout;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed checks of seq_chunk_adder with WIDTH=16 at
// CHUNK=4 (main instance), CHUNK=16 and CHUNK=1. Define ADDSUB_EN to also
// exercise subtraction on the main instance.
module tb_seq_chunk_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef ADDSUB_EN
  logic         sub = 1'b0;
`endif

  logic         busy, done, carry, overflow;
  logic [W-1:0] sum;
  logic         busy16, done16, carry16, overflow16;
  logic [W-1:0] sum16;
  logic         busy1, done1, carry1, overflow1;
  logic [W-1:0] sum1;

  int checks = 0;
  int errors = 0;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef ADDSUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
  );

  seq_chunk_adder #(.WIDTH(W), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef ADDSUB_EN
    .sub(1'b0),
`endif
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .overflow(overflow16)
  );

  seq_chunk_adder #(.WIDTH(W), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef ADDSUB_EN
    .sub(1'b0),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(overflow1)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with a one-cycle start pulse; returns just after the capture edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a = av;
    b = bv;
    cin = cv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges until the main instance raises done, giving up after 40.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sum: got %h want 0000", sum); end
    checks++; if (carry !== 1'b0) begin errors++; $display("[TB] FAIL reset_carry: got %b want 0", carry); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b want 0", overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_basic();
    int n;
    start_op(16'h1234, 16'h4321, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b want 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_done: got %b want 0", done); end
    wait_done(n);
    checks++; if (n != 4) begin errors++; $display("[TB] FAIL basic_latency: got %0d want 4", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done: got %b want 0", busy); end
    checks++; if (sum !== 16'h5555) begin errors++; $display("[TB] FAIL basic_sum: got %h want 5555", sum); end
    checks++; if (carry !== 1'b0) begin errors++; $display("[TB] FAIL basic_carry: got %b want 0", carry); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %b want 0", overflow); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b want 0", done); end
    checks++; if (sum !== 16'h5555) begin errors++; $display("[TB] FAIL basic_sum_held: got %h want 5555", sum); end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] va [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h00FF};
    logic [W-1:0] vb [4] = '{16'h0001, 16'h0000, 16'h8000, 16'h0F01};
    logic         vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] vs [4] = '{16'h0000, 16'h8000, 16'h0000, 16'h1000};
    logic         vo [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic         vv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int n;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], vc[i]);
      wait_done(n);
      checks++; if (sum !== vs[i]) begin errors++; $display("[TB] FAIL bound%0d_sum: got %h want %h", i, sum, vs[i]); end
      checks++; if (carry !== vo[i]) begin errors++; $display("[TB] FAIL bound%0d_carry: got %b want %b", i, carry, vo[i]); end
      checks++; if (overflow !== vv[i]) begin errors++; $display("[TB] FAIL bound%0d_ovf: got %b want %b", i, overflow, vv[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int n;
    int extra;
    tick();
    start_op(16'h0001, 16'h0001, 1'b0);
    a = 16'hAAAA;
    b = 16'h5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    wait_done(n);
    checks++; if (n != 3) begin errors++; $display("[TB] FAIL ignore_latency: got %0d want 3", n); end
    checks++; if (sum !== 16'h0002) begin errors++; $display("[TB] FAIL ignore_sum: got %h want 0002", sum); end
    checks++; if (carry !== 1'b0) begin errors++; $display("[TB] FAIL ignore_carry: got %b want 0", carry); end
    extra = 0;
    repeat (8) begin
      tick();
      if (done) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("[TB] FAIL ignore_single_done: got %0d extra want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int n;
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_done(n);
    checks++; if (sum !== 16'h5555) begin errors++; $display("[TB] FAIL b2b_first_sum: got %h want 5555", sum); end
    start_op(16'h7FFF, 16'h0000, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accepted: got %b want 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_drop: got %b want 0", done); end
    checks++; if (sum !== 16'h5555) begin errors++; $display("[TB] FAIL b2b_sum_held: got %h want 5555", sum); end
    wait_done(n);
    checks++; if (n != 4) begin errors++; $display("[TB] FAIL b2b_latency: got %0d want 4", n); end
    checks++; if (sum !== 16'h8000) begin errors++; $display("[TB] FAIL b2b_sum: got %h want 8000", sum); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ovf: got %b want 1", overflow); end
  endtask

  task automatic test_reset_abort();
    int n;
    int dones;
    tick();
    start_op(16'h1111, 16'h2222, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b want 0", done); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("[TB] FAIL abort_sum: got %h want 0000", sum); end
    checks++; if (carry !== 1'b0) begin errors++; $display("[TB] FAIL abort_carry: got %b want 0", carry); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL abort_ovf: got %b want 0", overflow); end
    tick();
    rst = 1'b0;
    dones = 0;
    repeat (8) begin
      tick();
      if (done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d want 0", dones); end
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_done(n);
    checks++; if (n != 4) begin errors++; $display("[TB] FAIL abort_restart_latency: got %0d want 4", n); end
    checks++; if (sum !== 16'h5555) begin errors++; $display("[TB] FAIL abort_restart_sum: got %h want 5555", sum); end
  endtask

  task automatic test_chunk_sizes();
    int n16;
    int n1;
    repeat (20) tick();
    start_op(16'h1234, 16'h4321, 1'b0);
    checks++; if (busy16 !== 1'b1) begin errors++; $display("[TB] FAIL c16_busy: got %b want 1", busy16); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("[TB] FAIL c1_busy: got %b want 1", busy1); end
    n16 = 0;
    n1 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done16 && n16 == 0) n16 = i;
      if (done1 && n1 == 0) n1 = i;
    end
    checks++; if (n16 != 1) begin errors++; $display("[TB] FAIL c16_latency: got %0d want 1", n16); end
    checks++; if (n1 != 16) begin errors++; $display("[TB] FAIL c1_latency: got %0d want 16", n1); end
    checks++; if (sum16 !== 16'h5555) begin errors++; $display("[TB] FAIL c16_sum: got %h want 5555", sum16); end
    checks++; if (sum1 !== 16'h5555) begin errors++; $display("[TB] FAIL c1_sum: got %h want 5555", sum1); end
    checks++; if ({carry16, overflow16} !== 2'b00) begin errors++; $display("[TB] FAIL c16_flags: got %b want 00", {carry16, overflow16}); end
    checks++; if ({carry1, overflow1} !== 2'b00) begin errors++; $display("[TB] FAIL c1_flags: got %b want 00", {carry1, overflow1}); end
  endtask

`ifdef ADDSUB_EN
  task automatic test_sub();
    int n;
    sub = 1'b1;
    start_op(16'h0005, 16'h0007, 1'b0);
    wait_done(n);
    checks++; if (sum !== 16'hFFFE) begin errors++; $display("[TB] FAIL sub1_sum: got %h want fffe", sum); end
    checks++; if (carry !== 1'b0) begin errors++; $display("[TB] FAIL sub1_carry: got %b want 0", carry); end
    start_op(16'h8000, 16'h0001, 1'b1);
    wait_done(n);
    checks++; if (sum !== 16'h7FFF) begin errors++; $display("[TB] FAIL sub2_sum: got %h want 7fff", sum); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL sub2_ovf: got %b want 1", overflow); end
    checks++; if (carry !== 1'b1) begin errors++; $display("[TB] FAIL sub2_carry: got %b want 1", carry); end
    sub = 1'b0;
  endtask
`endif

  // Runs every scenario in order, then prints the summary.
  initial begin
    test_reset();
    test_add_basic();
    test_boundaries();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_chunk_sizes();
`ifdef ADDSUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
